// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 matrix line driver: FSM states, default
// symbol timing and the GRB pixel layout used by the frame controller.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } tx_state_t;

  localparam int BIT_CYCLES       = 15;
  localparam int T0H_CYCLES       = 4;
  localparam int T1H_CYCLES       = 8;
  localparam int LATCH_CYCLES     = 900;
  localparam int PIXELS_PER_FRAME = 64;
  localparam int PIXEL_BITS       = 24;

  // Colour word is {G, R, B}; green goes out first on the wire.
  localparam int G_MSB = 23;
  localparam int G_LSB = 16;
  localparam int R_MSB = 15;
  localparam int R_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

endpackage

// File: rtl/ws2812_symbol_timer.sv
// Generates one NRZ bit symbol: counts BIT_CYCLES per symbol and drives the
// line high for the '0' or '1' high time at the start of each symbol.
module ws2812_symbol_timer
  import ws2812_pkg::*;
#(
  parameter int BIT_CYC = BIT_CYCLES,
  parameter int T0H_CYC = T0H_CYCLES,
  parameter int T1H_CYC = T1H_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic bit_value,
  output logic level,
  output logic symbol_end
);

  localparam int CW = $clog2(BIT_CYC);
  localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] T0H_CMP  = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H_CMP  = CW'(T1H_CYC);

  logic [CW-1:0] cyc_cnt;

  // Held at zero whenever disabled so each pixel starts on a fresh symbol.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable || cyc_cnt == LAST_CYC) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  assign symbol_end = enable && (cyc_cnt == LAST_CYC);
  assign level      = enable && (cyc_cnt < (bit_value ? T1H_CMP : T0H_CMP));

endmodule

// File: rtl/ws2812_pixel_tx.sv
// WS2812 pixel transmitter: accepts one GRB colour per start edge, shifts it out
// MSB first as NRZ symbols, and inserts the reset/latch gap after each frame.
module ws2812_pixel_tx
  import ws2812_pkg::*;
#(
  parameter int BIT_CYCLES_P   = BIT_CYCLES,
  parameter int T0H_CYCLES_P   = T0H_CYCLES,
  parameter int T1H_CYCLES_P   = T1H_CYCLES,
  parameter int BITS_PER_PIXEL = PIXEL_BITS,
  parameter int PIXELS_PER_FRM = PIXELS_PER_FRAME,
  parameter int LATCH_CYCLES_P = LATCH_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BITS_PER_PIXEL-1:0] color,
  output logic                      data_out,
  output logic                      busy,
  output logic                      pixel_done,
  output logic                      frame_done,
  output logic                      overrun
);

  localparam int BCW = $clog2(BITS_PER_PIXEL + 1);
  localparam int PCW = $clog2(PIXELS_PER_FRM);
  localparam int LCW = $clog2(LATCH_CYCLES_P);
  localparam logic [BCW-1:0] LAST_BIT   = BCW'(BITS_PER_PIXEL - 1);
  localparam logic [PCW-1:0] LAST_PIX   = PCW'(PIXELS_PER_FRM - 1);
  localparam logic [LCW-1:0] LAST_LATCH = LCW'(LATCH_CYCLES_P - 1);

  if (!(T0H_CYCLES_P < T1H_CYCLES_P && T1H_CYCLES_P < BIT_CYCLES_P)) begin : g_bad_timing
    $error("ws2812_pixel_tx: require T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
  end

  tx_state_t                 state;
  logic                      start_q;
  logic [BITS_PER_PIXEL-1:0] shreg;
  logic [BCW-1:0]            bit_cnt;
  logic [PCW-1:0]            pixel_count;
  logic [LCW-1:0]            latch_cnt;
  logic                      start_edge;
  logic                      symbol_end;
  logic                      tx_level;

  assign start_edge = start && !start_q;

  ws2812_symbol_timer #(
    .BIT_CYC (BIT_CYCLES_P),
    .T0H_CYC (T0H_CYCLES_P),
    .T1H_CYC (T1H_CYCLES_P)
  ) u_symbol_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (state == SEND),
    .bit_value  (shreg[BITS_PER_PIXEL-1]),
    .level      (tx_level),
    .symbol_end (symbol_end)
  );

  assign data_out = tx_level;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      pixel_count <= '0;
      latch_cnt   <= '0;
      pixel_done  <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      start_q    <= start;
      pixel_done <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      case (state)
        // The cycle IDLE is re-entered still carries the done pulse; edges
        // landing there are deliberately ignored.
        IDLE: begin
          if (start_edge && !pixel_done && !frame_done) begin
            shreg   <= color;
            bit_cnt <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (start_edge) overrun <= 1'b1;
          if (symbol_end) begin
            shreg   <= {shreg[BITS_PER_PIXEL-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              pixel_done <= 1'b1;
              if (pixel_count == LAST_PIX) begin
                pixel_count <= '0;
                latch_cnt   <= '0;
                state       <= LATCH;
              end else begin
                pixel_count <= pixel_count + 1'b1;
                state       <= IDLE;
              end
            end
          end
        end
        LATCH: begin
          if (start_edge) overrun <= 1'b1;
          if (latch_cnt == LAST_LATCH) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end else begin
            latch_cnt <= latch_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
